// File: rtl/ctrl_sequencer_if.sv
// ctrl_sequencer_if: instruction ROM, ALU and register-decoder signals of the sequencer
interface ctrl_sequencer_if #(parameter int PC_W = 8);
  logic            start;
  logic [7:0]      instr_data;
  logic            z_flag;
  logic            alu_done;
  logic [PC_W-1:0] pc;
  logic [3:0]      sel;
  logic            en_op;
  logic            en_out;
  logic [2:0]      alu_op;
  logic            alu_go;
  logic            busy;
  logic            done;
  logic            err;
  modport master (
    input  start, instr_data, z_flag, alu_done,
    output pc, sel, en_op, en_out, alu_op, alu_go, busy, done, err
  );
  modport slave (
    output start, instr_data, z_flag, alu_done,
    input  pc, sel, en_op, en_out, alu_op, alu_go, busy, done, err
  );
endinterface

// File: rtl/ctrl_sequencer.sv
// ctrl_sequencer: fetch/decode FSM driving a register-enable decoder and an ALU from an 8-bit ROM
module ctrl_sequencer #(
  parameter int PC_W    = 8,
  parameter int ALU_TMO = 15
) (
  input logic              clk,
  input logic              rst,
  ctrl_sequencer_if.master bus
);
  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_LATCH, S_WRITE, S_ALUWAIT, S_OPFETCH, S_OPCAP, S_HALT
  } state_t;
  localparam int CW = $clog2(ALU_TMO + 1);
  state_t          r_state, w_state;
  logic [PC_W-1:0] r_pc, w_pc, w_pc_inc;
  logic [7:0]      r_ir, w_ir;
  logic [2:0]      r_alu_op, w_alu_op;
  logic [CW-1:0]   r_cnt, w_cnt;
  logic            r_en_op, w_en_op, r_en_out, w_en_out, r_alu_go, w_alu_go, r_err, w_err;
  assign w_pc_inc = r_pc + 1'b1;
  always_comb begin
    w_state  = r_state;
    w_pc     = r_pc;
    w_ir     = r_ir;
    w_alu_op = r_alu_op;
    w_cnt    = r_cnt;
    w_err    = r_err;
    w_en_op  = 1'b0;
    w_en_out = 1'b0;
    w_alu_go = 1'b0;
    case (r_state)
      S_IDLE, S_HALT: if (bus.start) begin
        w_state = S_FETCH;
        w_pc    = '0;
        w_err   = 1'b0;
      end
      S_FETCH: w_state = S_DECODE;
      S_DECODE: begin
        w_ir = bus.instr_data;
        case (bus.instr_data[7:4])
          4'h0: begin w_pc = w_pc_inc; w_state = S_FETCH; end
          4'h1: begin w_en_op = 1'b1; w_state = S_LATCH; end
          4'h2: begin w_alu_op = bus.instr_data[2:0]; w_alu_go = 1'b1; w_cnt = '0; w_state = S_ALUWAIT; end
          4'h3, 4'h4: begin w_pc = w_pc_inc; w_state = S_OPFETCH; end
          4'hF: w_state = S_HALT;
          default: begin w_err = 1'b1; w_pc = w_pc_inc; w_state = S_FETCH; end
        endcase
      end
      S_LATCH: begin w_en_out = 1'b1; w_state = S_WRITE; end
      S_WRITE: begin w_pc = w_pc_inc; w_state = S_FETCH; end
      // a completion in the last allowed cycle still wins over the timeout
      S_ALUWAIT: if (bus.alu_done || r_cnt == CW'(ALU_TMO - 1)) begin
        w_pc    = w_pc_inc;
        w_err   = r_err | ~bus.alu_done;
        w_state = S_FETCH;
      end else w_cnt = r_cnt + 1'b1;
      S_OPFETCH: w_state = S_OPCAP;
      S_OPCAP: begin
        w_pc    = (r_ir[7:4] == 4'h4 || bus.z_flag) ? PC_W'(bus.instr_data) : w_pc_inc;
        w_state = S_FETCH;
      end
      default: w_state = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_pc     <= '0;
      r_ir     <= '0;
      r_alu_op <= '0;
      r_cnt    <= '0;
      r_err    <= 1'b0;
      r_en_op  <= 1'b0;
      r_en_out <= 1'b0;
      r_alu_go <= 1'b0;
    end else begin
      r_state  <= w_state;
      r_pc     <= w_pc;
      r_ir     <= w_ir;
      r_alu_op <= w_alu_op;
      r_cnt    <= w_cnt;
      r_err    <= w_err;
      r_en_op  <= w_en_op;
      r_en_out <= w_en_out;
      r_alu_go <= w_alu_go;
    end
  end
  assign bus.pc     = r_pc;
  assign bus.sel    = r_ir[3:0];
  assign bus.en_op  = r_en_op;
  assign bus.en_out = r_en_out;
  assign bus.alu_op = r_alu_op;
  assign bus.alu_go = r_alu_go;
  assign bus.err    = r_err;
  assign bus.done   = (r_state == S_HALT);
  assign bus.busy   = (r_state != S_IDLE) && (r_state != S_HALT);
endmodule

// File: tb/tb_ctrl_sequencer.sv
// tb_ctrl_sequencer: directed vector table, corner sequences and random programs vs an instruction-level model
module tb_ctrl_sequencer;
  localparam int PC_W  = 8;
  localparam int NEVER = 255;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  ctrl_sequencer_if #(.PC_W(PC_W)) bus();
  ctrl_sequencer #(.PC_W(PC_W), .ALU_TMO(15)) dut (.clk(clk), .rst(rst), .bus(bus));
  logic [7:0] rom [256];
  always_ff @(posedge clk) bus.instr_data <= rom[bus.pc];
  typedef struct {
    int b0, b1, z, d, hold, cyc, pc, err, aop, nalu, nld, lsel;
  } vec_t;
  vec_t vt [11];
  int n_chk = 0, n_pass = 0;
  int dq [$];
  int dcnt, n_enout, n_enop, n_alu, n_viol, last_sel;
  int sel_sig, alu_sig;
  logic prev_en_op;
  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask
  task automatic clear_logs();
    n_enout = 0; n_enop = 0; n_alu = 0; n_viol = 0; last_sel = 0;
    sel_sig = 0; alu_sig = 0; prev_en_op = 1'b0;
  endtask
  // one clock; sample outputs 1 time unit after the edge and act as the ALU
  task automatic tick();
    int d;
    @(posedge clk);
    #1;
    bus.alu_done = 1'b0;
    if (dcnt > 0) begin
      dcnt--;
      if (dcnt == 0) bus.alu_done = 1'b1;
    end
    if (bus.alu_go) begin
      d = (dq.size() > 0) ? dq.pop_front() : NEVER;
      n_alu++;
      alu_sig = alu_sig * 31 + int'(bus.alu_op) + 1;
      if (d == 0) bus.alu_done = 1'b1;
      else if (d != NEVER) dcnt = d;
    end
    if (bus.en_op) begin
      n_enop++;
      last_sel = int'(bus.sel);
      sel_sig = sel_sig * 31 + int'(bus.sel) + 1;
    end
    if (bus.en_out) n_enout++;
    if ((bus.en_op && bus.en_out) || (bus.en_out != prev_en_op)) n_viol++;
    prev_en_op = bus.en_op;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    bus.start = 1'b0;
    bus.alu_done = 1'b0;
    dcnt = 0;
    dq.delete();
    tick();
    tick();
    rst = 1'b0;
    clear_logs();
  endtask
  function automatic logic [7:0] gen();
    int r;
    logic [3:0] opnd;
    r = $urandom_range(0, 15);
    opnd = 4'($urandom_range(0, 15));
    if (r < 4)  return {4'h0, opnd};
    if (r < 7)  return {4'h1, opnd};
    if (r < 10) return {4'h2, opnd};
    if (r == 10) return {4'h3, opnd};
    if (r == 11) return {4'h4, opnd};
    if (r == 12) return {4'hF, opnd};
    return {4'($urandom_range(5, 14)), opnd};
  endfunction
  initial begin
    int n;
    bus.start = 1'b0;
    bus.z_flag = 1'b0;
    bus.alu_done = 1'b0;
    foreach (rom[i]) rom[i] = 8'hF0;
    do_reset();
    chk("rst_pc", int'(bus.pc), 0);     chk("rst_sel", int'(bus.sel), 0);
    chk("rst_alu_op", int'(bus.alu_op), 0); chk("rst_en_op", int'(bus.en_op), 0);
    chk("rst_en_out", int'(bus.en_out), 0); chk("rst_alu_go", int'(bus.alu_go), 0);
    chk("rst_busy", int'(bus.busy), 0); chk("rst_done", int'(bus.done), 0);
    chk("rst_err", int'(bus.err), 0);
    // b0 b1 z delay hold | cycles pc err alu_op n_alu n_load last_sel
    vt = '{
      '{'h15, 'hF0, 0, 0,     0,  6, 'h01, 0, 0, 0, 1, 5},
      '{'h30, 'h07, 1, 0,     0,  6, 'h07, 0, 0, 0, 0, 0},
      '{'h30, 'h07, 0, 0,     0,  6, 'h02, 0, 0, 0, 0, 0},
      '{'h26, 'hF0, 0, 3,     0,  8, 'h01, 0, 6, 1, 0, 0},
      '{'h21, 'hF0, 0, NEVER, 0, 19, 'h01, 1, 1, 1, 0, 0},
      '{'h21, 'hF0, 0, NEVER, 1, 19, 'h01, 1, 1, 1, 0, 0},
      '{'h26, 'hF0, 0, 14,    0, 19, 'h01, 0, 6, 1, 0, 0},
      '{'h22, 'hF0, 0, 0,     0,  5, 'h01, 0, 2, 1, 0, 0},
      '{'h40, 'h85, 0, 0,     0,  6, 'h85, 0, 0, 0, 0, 0},
      '{'h9A, 'hF0, 0, 0,     0,  4, 'h01, 1, 0, 0, 0, 0},
      '{'h00, 'hF0, 0, 0,     0,  4, 'h01, 0, 0, 0, 0, 0}
    };
    for (int v = 0; v < 11; v++) begin
      foreach (rom[i]) rom[i] = 8'hF0;
      rom[0] = 8'(vt[v].b0);
      rom[1] = 8'(vt[v].b1);
      do_reset();
      bus.z_flag = vt[v].z[0];
      dq.push_back(vt[v].d);
      bus.start = 1'b1;
      tick();
      bus.start = vt[v].hold[0];
      n = 0;
      while (!bus.done && n < 100) begin tick(); n++; end
      bus.start = 1'b0;
      chk($sformatf("v%0d_cycles", v), n, vt[v].cyc);
      chk($sformatf("v%0d_pc", v), int'(bus.pc), vt[v].pc);
      chk($sformatf("v%0d_err", v), int'(bus.err), vt[v].err);
      chk($sformatf("v%0d_alu_op", v), int'(bus.alu_op), vt[v].aop);
      chk($sformatf("v%0d_alu_go_count", v), n_alu, vt[v].nalu);
      chk($sformatf("v%0d_en_op_count", v), n_enop, vt[v].nld);
      chk($sformatf("v%0d_sel", v), last_sel, vt[v].lsel);
      chk($sformatf("v%0d_pulse_order", v), n_viol, 0);
    end
    // pc wrap: jump to 0xFF, a NOP there must roll pc to 0 without error
    foreach (rom[i]) rom[i] = 8'h00;
    rom[0] = 8'h40; rom[1] = 8'hFF;
    do_reset();
    bus.start = 1'b1; tick(); bus.start = 1'b0;
    repeat (4) tick();
    chk("wrap_at_ff", int'(bus.pc), 'hFF);
    repeat (2) tick();
    chk("wrap_to_0", int'(bus.pc), 0);
    chk("wrap_busy", int'(bus.busy), 1);
    chk("wrap_err", int'(bus.err), 0);
    // sticky error cleared only by the next start
    foreach (rom[i]) rom[i] = 8'hF0;
    rom[0] = 8'h9A; rom[1] = 8'h00;
    do_reset();
    bus.start = 1'b1; tick(); bus.start = 1'b0;
    n = 0;
    while (!bus.done && n < 50) begin tick(); n++; end
    chk("sticky_done", int'(bus.done), 1);
    chk("sticky_err", int'(bus.err), 1);
    chk("sticky_pc", int'(bus.pc), 2);
    rom[0] = 8'h00;
    bus.start = 1'b1; tick(); bus.start = 1'b0;
    chk("restart_err_clr", int'(bus.err), 0);
    chk("restart_pc", int'(bus.pc), 0);
    // reset while in LATCH must suppress the pending en_out
    foreach (rom[i]) rom[i] = 8'hF0;
    rom[0] = 8'h15;
    do_reset();
    bus.start = 1'b1; tick(); bus.start = 1'b0;
    tick(); tick();
    chk("latch_en_op", int'(bus.en_op), 1);
    rst = 1'b1; tick();
    chk("rstl_en_op", int'(bus.en_op), 0);
    chk("rstl_en_out", int'(bus.en_out), 0);
    chk("rstl_pc", int'(bus.pc), 0);
    chk("rstl_busy", int'(bus.busy), 0);
    rst = 1'b0;
    n_enout = 0;
    repeat (6) tick();
    chk("rstl_no_en_out", n_enout, 0);
    chk("rstl_idle", int'(bus.busy) + int'(bus.done), 0);
    // random programs against an instruction-level model
    for (int run = 0; run < 25; run++) begin
      logic [7:0] m_pc, a, ins;
      int m_err, m_cyc, m_halt, e_sel_sig, e_alu_sig, e_nld, d;
      logic z;
      foreach (rom[i]) rom[i] = gen();
      do_reset();
      z = 1'($urandom_range(0, 1));
      bus.z_flag = z;
      m_pc = 8'h00; m_err = 0; m_cyc = 0; m_halt = 0;
      e_sel_sig = 0; e_alu_sig = 0; e_nld = 0;
      for (int k = 0; k < 40 && m_halt == 0; k++) begin
        ins = rom[m_pc];
        a = m_pc + 8'd1;
        case (ins[7:4])
          4'h0: begin m_pc = a; m_cyc += 2; end
          4'h1: begin
            e_sel_sig = e_sel_sig * 31 + int'(ins[3:0]) + 1; e_nld++;
            m_pc = a; m_cyc += 4;
          end
          4'h2: begin
            e_alu_sig = e_alu_sig * 31 + int'(ins[2:0]) + 1;
            d = $urandom_range(0, 19);
            if (d >= 15) begin d = NEVER; m_err = 1; m_cyc += 17; end
            else m_cyc += 3 + d;
            dq.push_back(d);
            m_pc = a;
          end
          4'h3: begin m_pc = z ? rom[a] : a + 8'd1; m_cyc += 4; end
          4'h4: begin m_pc = rom[a]; m_cyc += 4; end
          4'hF: begin m_halt = 1; m_cyc += 2; end
          default: begin m_err = 1; m_pc = a; m_cyc += 2; end
        endcase
      end
      bus.start = 1'b1; tick(); bus.start = 1'b0;
      repeat (m_cyc) tick();
      chk($sformatf("r%0d_pc", run), int'(bus.pc), int'(m_pc));
      chk($sformatf("r%0d_err", run), int'(bus.err), m_err);
      chk($sformatf("r%0d_done", run), int'(bus.done), m_halt);
      chk($sformatf("r%0d_busy", run), int'(bus.busy), 1 - m_halt);
      chk($sformatf("r%0d_sel_log", run), sel_sig, e_sel_sig);
      chk($sformatf("r%0d_alu_log", run), alu_sig, e_alu_sig);
      chk($sformatf("r%0d_en_out_count", run), n_enout, e_nld);
      chk($sformatf("r%0d_pulse_order", run), n_viol, 0);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
